// File: rtl/dec_syndrome_ctrl.sv
// Sequencing controller for the (16,11) SECDED syndrome multiplier: issues the operand, samples the
// syndrome after MUL_LATENCY cycles, corrects/classifies the error and keeps saturating error counters.
module dec_syndrome_ctrl #(
   parameter int MUL_LATENCY = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      codeword_in,
   output logic [15:0]      mul_operand,
   input  logic [4:0]       mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [10:0]      data_out,
   output logic             err_single,
   output logic             err_double,
   output logic [3:0]       err_pos,
   input  logic             clr_counters,
   output logic [CNT_W-1:0] single_cnt,
   output logic [CNT_W-1:0] double_cnt
);
   localparam int WCW = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;
   localparam logic [WCW-1:0] WAIT_LOAD = WCW'(MUL_LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, CORR, OUT} state_t;

   state_t         state, state_nxt;
   logic [10:0]    cw_data;
   logic [4:0]     syn;
   logic [WCW-1:0] wait_cnt;
   logic           accept;
   logic [3:0]     col_bit;
   logic [10:0]    flip_mask;
   logic [10:0]    corr_data;
   logic           corr_single;
   logic           corr_double;
   logic [3:0]     corr_pos;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nxt = WAIT;
         end
         WAIT: if (wait_cnt == '0) state_nxt = CORR;
         CORR: state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Positional syndrome back to bit index; S=0 resolves to the overall parity bit 11.
   always_comb begin
      col_bit = 4'd11;
      case (syn[4:1])
         4'b1111: col_bit = 4'd0;
         4'b0111: col_bit = 4'd1;
         4'b1011: col_bit = 4'd2;
         4'b0011: col_bit = 4'd3;
         4'b1101: col_bit = 4'd4;
         4'b0101: col_bit = 4'd5;
         4'b1001: col_bit = 4'd6;
         4'b1110: col_bit = 4'd7;
         4'b0110: col_bit = 4'd8;
         4'b1010: col_bit = 4'd9;
         4'b1100: col_bit = 4'd10;
         4'b0001: col_bit = 4'd12;
         4'b0010: col_bit = 4'd13;
         4'b0100: col_bit = 4'd14;
         4'b1000: col_bit = 4'd15;
         default: col_bit = 4'd11;
      endcase
      flip_mask   = 11'd1 << col_bit;
      corr_data   = cw_data;
      corr_single = 1'b0;
      corr_double = 1'b0;
      corr_pos    = 4'd0;
      if (syn[0]) begin
         corr_single = 1'b1;
         corr_pos    = col_bit;
         corr_data   = cw_data ^ flip_mask;
      end else if (syn[4:1] != 4'd0) begin
         corr_double = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mul_operand <= '0;
         cw_data     <= '0;
         syn         <= '0;
         wait_cnt    <= '0;
         data_out    <= '0;
         err_single  <= 1'b0;
         err_double  <= 1'b0;
         err_pos     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mul_operand <= codeword_in;
            cw_data     <= codeword_in[10:0];
            wait_cnt    <= WAIT_LOAD;
         end
         if (state == WAIT) begin
            if (wait_cnt == '0) syn <= mul_result;
            else                wait_cnt <= wait_cnt - 1'b1;
         end
         if (state == CORR) begin
            data_out   <= corr_data;
            err_single <= corr_single;
            err_double <= corr_double;
            err_pos    <= corr_pos;
         end
      end
   end

   // Clear wins over a coincident increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         single_cnt <= '0;
         double_cnt <= '0;
      end else if (clr_counters) begin
         single_cnt <= '0;
         double_cnt <= '0;
      end else if (state == CORR) begin
         if (corr_single && (single_cnt != '1)) single_cnt <= single_cnt + 1'b1;
         if (corr_double && (double_cnt != '1)) double_cnt <= double_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_dec_syndrome_ctrl.sv
// Bench for dec_syndrome_ctrl: one instance with a combinational multiplier model, one with a
// two-stage multiplier model and 3-bit counters; expectations go through scoreboard queues.
module tb_dec_syndrome_ctrl;
   typedef struct packed {
      logic [10:0] data;
      logic        single;
      logic        dbl;
      logic [3:0]  pos;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        in_valid, in_ready, out_valid, out_ready, err_single, err_double, clr_counters;
   logic [15:0] codeword_in, mul_operand;
   logic [4:0]  mul_result;
   logic [10:0] data_out;
   logic [3:0]  err_pos;
   logic [15:0] single_cnt, double_cnt;

   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_single_b, err_double_b, clr_counters_b;
   logic [15:0] codeword_in_b, mul_operand_b;
   logic [4:0]  mul_result_b, pipe1_b, pipe2_b;
   logic [10:0] data_out_b;
   logic [3:0]  err_pos_b;
   logic [2:0]  single_cnt_b, double_cnt_b;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t exp_q_b[$];
   int   sc = 0;
   int   dc = 0;

   function automatic logic [3:0] col(input int i);
      case (i)
         0: return 4'b1111;   1: return 4'b0111;   2: return 4'b1011;   3: return 4'b0011;
         4: return 4'b1101;   5: return 4'b0101;   6: return 4'b1001;   7: return 4'b1110;
         8: return 4'b0110;   9: return 4'b1010;  10: return 4'b1100;  12: return 4'b0001;
         13: return 4'b0010; 14: return 4'b0100;  15: return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [4:0] syn_of(input logic [15:0] w);
      logic [3:0] s;
      s = 4'd0;
      for (int i = 0; i < 16; i++) if (w[i]) s = s ^ col(i);
      return {s, ^w};
   endfunction

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] w;
      logic [4:0]  s;
      w = {5'd0, d};
      s = syn_of(w);
      w[15:12] = s[4:1];
      w[11] = ^w;
      return w;
   endfunction

   function automatic exp_t model(input logic [15:0] w);
      exp_t       e;
      logic [4:0] s;
      s = syn_of(w);
      e = '0;
      e.data = w[10:0];
      if (s[0]) begin
         e.single = 1'b1;
         e.pos = 4'd11;
         for (int i = 0; i < 16; i++)
            if (i != 11 && col(i) == s[4:1]) begin
               e.pos = 4'(i);
               if (i < 11) e.data = e.data ^ (11'd1 << i);
            end
      end else if (s[4:1] != 4'd0) begin
         e.dbl = 1'b1;
      end
      return e;
   endfunction

   assign mul_result = syn_of(mul_operand);
   always @(posedge clk) begin
      pipe1_b <= syn_of(mul_operand_b);
      pipe2_b <= pipe1_b;
   end
   assign mul_result_b = pipe2_b;

   dec_syndrome_ctrl #(.MUL_LATENCY(0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .codeword_in(codeword_in),
      .mul_operand(mul_operand), .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .err_single(err_single), .err_double(err_double), .err_pos(err_pos),
      .clr_counters(clr_counters), .single_cnt(single_cnt), .double_cnt(double_cnt));

   dec_syndrome_ctrl #(.MUL_LATENCY(2), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .codeword_in(codeword_in_b),
      .mul_operand(mul_operand_b), .mul_result(mul_result_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .data_out(data_out_b), .err_single(err_single_b), .err_double(err_double_b), .err_pos(err_pos_b),
      .clr_counters(clr_counters_b), .single_cnt(single_cnt_b), .double_cnt(double_cnt_b));

   task automatic send_a(input logic [15:0] w, output int lat);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      codeword_in = w;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      exp_q.push_back(model(w));
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
   endtask

   task automatic send_b(input logic [15:0] w, output int lat);
      int n = 0;
      @(negedge clk);
      in_valid_b = 1'b1;
      codeword_in_b = w;
      while (!in_ready_b && n < 50) begin @(negedge clk); n++; end
      exp_q_b.push_back(model(w));
      @(negedge clk);
      in_valid_b = 1'b0;
      lat = 1;
      while (!out_valid_b && lat < 60) begin @(negedge clk); lat++; end
   endtask

   task automatic ack_a();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic ack_b();
      out_ready_b = 1'b1;
      @(negedge clk);
      out_ready_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; clr_counters = 1'b0; codeword_in = '0;
      in_valid_b = 1'b0; out_ready_b = 1'b0; clr_counters_b = 1'b0; codeword_in_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++; $display("FAIL reset_handshake ready/valid=%b expected 10", {in_ready, out_valid});
      end
      checks++;
      if (mul_operand !== 16'h0) begin
         failures++; $display("FAIL reset_operand got=%h expected 0000", mul_operand);
      end
      checks++;
      if ({data_out, err_single, err_double, err_pos} !== 17'h0) begin
         failures++; $display("FAIL reset_outputs got=%h expected 0", {data_out, err_single, err_double, err_pos});
      end
      checks++;
      if ({single_cnt, double_cnt} !== 32'h0) begin
         failures++; $display("FAIL reset_counters got=%h expected 0", {single_cnt, double_cnt});
      end
      checks++;
      if ({in_ready_b, out_valid_b, single_cnt_b, double_cnt_b} !== 8'b1000_0000) begin
         failures++; $display("FAIL reset_b got=%b expected 10000000",
                              {in_ready_b, out_valid_b, single_cnt_b, double_cnt_b});
      end
   endtask

   task automatic test_clean();
      int lat; exp_t e, act; logic [15:0] w;
      for (int k = 0; k < 4; k++) begin
         w = (k == 0) ? 16'h0000 : encode(11'($urandom));
         send_a(w, lat);
         checks++;
         if (lat !== 3) begin failures++; $display("FAIL clean_latency got=%0d expected 3", lat); end
         e = exp_q.pop_front();
         act = {data_out, err_single, err_double, err_pos};
         checks++;
         if (act !== e || act !== {w[10:0], 6'b0}) begin
            failures++; $display("FAIL clean_result got=%h expected=%h", act, {w[10:0], 6'b0});
         end
         ack_a();
      end
      checks++;
      if ({single_cnt, double_cnt} !== 32'h0) begin
         failures++; $display("FAIL clean_counters got=%h expected 0", {single_cnt, double_cnt});
      end
   endtask

   task automatic test_single();
      int lat; exp_t e, act; logic [15:0] w;
      logic [15:0] fixed_w [0:1];
      exp_t        fixed_e [0:1];
      fixed_w[0] = 16'h0020; fixed_e[0] = {11'h000, 1'b1, 1'b0, 4'd5};
      fixed_w[1] = 16'h0800; fixed_e[1] = {11'h000, 1'b1, 1'b0, 4'd11};
      for (int k = 0; k < 8; k++) begin
         w = (k < 2) ? fixed_w[k] : (encode(11'($urandom)) ^ (16'd1 << $urandom_range(0, 15)));
         send_a(w, lat);
         sc++;
         e = exp_q.pop_front();
         act = {data_out, err_single, err_double, err_pos};
         checks++;
         if (lat !== 3 || act !== e) begin
            failures++; $display("FAIL single_result cw=%h lat=%0d got=%h expected=%h", w, lat, act, e);
         end
         checks++;
         if (k < 2 && act !== fixed_e[k]) begin
            failures++; $display("FAIL single_known cw=%h got=%h expected=%h", w, act, fixed_e[k]);
         end
         ack_a();
         checks++;
         if (mul_operand !== w) begin
            failures++; $display("FAIL operand_hold got=%h expected=%h", mul_operand, w);
         end
      end
      checks++;
      if (single_cnt !== 16'(sc) || double_cnt !== 16'(dc)) begin
         failures++; $display("FAIL single_counters got=%0d/%0d expected=%0d/%0d", single_cnt, double_cnt, sc, dc);
      end
   endtask

   task automatic test_double();
      int lat, b1, b2; exp_t e, act; logic [15:0] w;
      for (int k = 0; k < 5; k++) begin
         b1 = $urandom_range(0, 15);
         b2 = (b1 + $urandom_range(1, 15)) % 16;
         w = (k == 0) ? 16'h0021 : (encode(11'($urandom)) ^ (16'd1 << b1) ^ (16'd1 << b2));
         send_a(w, lat);
         dc++;
         e = exp_q.pop_front();
         act = {data_out, err_single, err_double, err_pos};
         checks++;
         if (lat !== 3 || act !== e || act !== {w[10:0], 6'b010000}) begin
            failures++; $display("FAIL double_result cw=%h lat=%0d got=%h expected=%h", w, lat, act, e);
         end
         ack_a();
      end
      checks++;
      if (double_cnt !== 16'(dc) || single_cnt !== 16'(sc)) begin
         failures++; $display("FAIL double_counters got=%0d/%0d expected=%0d/%0d", single_cnt, double_cnt, sc, dc);
      end
   endtask

   task automatic test_backpressure();
      int lat; exp_t e, act; logic [15:0] w1, w2;
      w1 = encode(11'($urandom)) ^ 16'h0008;
      w2 = encode(11'($urandom)) ^ 16'h0400;
      send_a(w1, lat);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL bp_latency1 got=%0d expected 3", lat); end
      e = exp_q.pop_front();
      in_valid = 1'b1;
      codeword_in = w2;
      for (int k = 0; k < 5; k++) begin
         act = {data_out, err_single, err_double, err_pos};
         checks++;
         if (act !== e || out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold cyc=%0d valid=%b got=%h expected=%h", k, out_valid, act, e);
         end
         checks++;
         if (in_ready !== 1'b0 || mul_operand !== w1) begin
            failures++; $display("FAIL bp_no_accept cyc=%0d ready=%b operand=%h expected 0/%h", k, in_ready, mul_operand, w1);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10 || mul_operand !== w1) begin
         failures++; $display("FAIL bp_release ready/valid=%b operand=%h expected 10/%h", {in_ready, out_valid}, mul_operand, w1);
      end
      exp_q.push_back(model(w2));
      sc++;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mul_operand !== w2) begin
         failures++; $display("FAIL bp_second_accept operand=%h expected=%h", mul_operand, w2);
      end
      lat = 1;
      while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
      e = exp_q.pop_front();
      act = {data_out, err_single, err_double, err_pos};
      checks++;
      if (lat !== 3 || act !== e) begin
         failures++; $display("FAIL bp_second lat=%0d got=%h expected=%h", lat, act, e);
      end
      ack_a();
   endtask

   task automatic test_latency2();
      int lat; exp_t e, act; logic [15:0] w1, w2;
      w1 = encode(11'($urandom)) ^ 16'h0001;
      w2 = encode(11'($urandom)) ^ 16'h8000;
      send_b(w1, lat);
      e = exp_q_b.pop_front();
      checks++;
      if (lat !== 5) begin failures++; $display("FAIL lat2_latency got=%0d expected 5", lat); end
      in_valid_b = 1'b1;
      codeword_in_b = w2;
      for (int k = 0; k < 3; k++) begin
         act = {data_out_b, err_single_b, err_double_b, err_pos_b};
         checks++;
         if (act !== e || out_valid_b !== 1'b1 || in_ready_b !== 1'b0) begin
            failures++; $display("FAIL lat2_hold cyc=%0d valid=%b ready=%b got=%h expected=%h",
                                 k, out_valid_b, in_ready_b, act, e);
         end
         @(negedge clk);
      end
      out_ready_b = 1'b1;
      @(negedge clk);
      out_ready_b = 1'b0;
      exp_q_b.push_back(model(w2));
      @(negedge clk);
      in_valid_b = 1'b0;
      lat = 1;
      while (!out_valid_b && lat < 60) begin @(negedge clk); lat++; end
      e = exp_q_b.pop_front();
      act = {data_out_b, err_single_b, err_double_b, err_pos_b};
      checks++;
      if (lat !== 5 || act !== e) begin
         failures++; $display("FAIL lat2_second lat=%0d got=%h expected=%h", lat, act, e);
      end
      ack_b();
   endtask

   task automatic test_counters();
      int lat, n; exp_t e, act; logic [15:0] w;
      for (int k = 0; k < 9; k++) begin
         w = encode(11'($urandom)) ^ (16'd1 << $urandom_range(0, 15));
         send_b(w, lat);
         e = exp_q_b.pop_front();
         act = {data_out_b, err_single_b, err_double_b, err_pos_b};
         checks++;
         if (act !== e) begin failures++; $display("FAIL sat_result got=%h expected=%h", act, e); end
         ack_b();
         checks++;
         if (single_cnt_b !== 3'((k + 3 > 7) ? 7 : k + 3)) begin
            failures++; $display("FAIL sat_single k=%0d got=%0d expected=%0d", k, single_cnt_b, (k + 3 > 7) ? 7 : k + 3);
         end
      end
      send_b(encode(11'h155) ^ 16'h0041, lat);
      e = exp_q_b.pop_front();
      ack_b();
      checks++;
      if (double_cnt_b !== 3'd1) begin failures++; $display("FAIL dbl_count_b got=%0d expected 1", double_cnt_b); end
      // Clear lands on the CORR->OUT edge of a single-error word.
      w = encode(11'h2aa) ^ 16'h0100;
      @(negedge clk);
      in_valid_b = 1'b1;
      codeword_in_b = w;
      n = 0;
      while (!in_ready_b && n < 50) begin @(negedge clk); n++; end
      exp_q_b.push_back(model(w));
      @(negedge clk);
      in_valid_b = 1'b0;
      repeat (3) @(negedge clk);
      clr_counters_b = 1'b1;
      @(negedge clk);
      clr_counters_b = 1'b0;
      e = exp_q_b.pop_front();
      act = {data_out_b, err_single_b, err_double_b, err_pos_b};
      checks++;
      if (out_valid_b !== 1'b1 || act !== e) begin
         failures++; $display("FAIL clr_corr_result valid=%b got=%h expected=%h", out_valid_b, act, e);
      end
      checks++;
      if ({single_cnt_b, double_cnt_b} !== 6'd0) begin
         failures++; $display("FAIL clr_priority got=%0d/%0d expected 0/0", single_cnt_b, double_cnt_b);
      end
      ack_b();
      clr_counters = 1'b1;
      @(negedge clk);
      clr_counters = 1'b0;
      sc = 0;
      dc = 0;
      checks++;
      if ({single_cnt, double_cnt} !== 32'h0) begin
         failures++; $display("FAIL clr_idle got=%0d/%0d expected 0/0", single_cnt, double_cnt);
      end
   endtask

   task automatic test_reset_wait();
      int lat, n; exp_t e, act; logic [15:0] w;
      bit spurious;
      send_b(encode(11'h0f0) ^ 16'h0004, lat);
      e = exp_q_b.pop_front();
      ack_b();
      send_a(encode(11'h00f) ^ 16'h0002, lat);
      e = exp_q.pop_front();
      ack_a();
      @(negedge clk);
      in_valid_b = 1'b1;
      codeword_in_b = encode(11'h333) ^ 16'h0010;
      n = 0;
      while (!in_ready_b && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid_b = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q_b.delete();
      exp_q.delete();
      sc = 0;
      dc = 0;
      #1;
      checks++;
      if ({in_ready_b, out_valid_b} !== 2'b10) begin
         failures++; $display("FAIL rstw_handshake ready/valid=%b expected 10", {in_ready_b, out_valid_b});
      end
      checks++;
      if ({single_cnt_b, double_cnt_b, single_cnt, double_cnt} !== 38'd0) begin
         failures++; $display("FAIL rstw_counters got b=%0d/%0d a=%0d/%0d expected 0", single_cnt_b, double_cnt_b,
                              single_cnt, double_cnt);
      end
      spurious = 1'b0;
      repeat (8) begin @(negedge clk); if (out_valid_b) spurious = 1'b1; end
      checks++;
      if (spurious) begin failures++; $display("FAIL rstw_dropped out_valid seen=1 expected 0"); end
      w = encode(11'h5a5) ^ 16'h0200;
      send_b(w, lat);
      e = exp_q_b.pop_front();
      act = {data_out_b, err_single_b, err_double_b, err_pos_b};
      checks++;
      if (lat !== 5 || act !== e) begin
         failures++; $display("FAIL rstw_next lat=%0d got=%h expected=%h", lat, act, e);
      end
      ack_b();
      checks++;
      if (single_cnt_b !== 3'd1) begin failures++; $display("FAIL rstw_count got=%0d expected 1", single_cnt_b); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single();
      test_double();
      test_backpressure();
      test_latency2();
      test_counters();
      test_reset_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish by 100000ns");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end
endmodule

// File: doc/dec_syndrome_ctrl.md
Name: dec_syndrome_ctrl

Overview:
Sequencing controller for the 16-bit SECDED syndrome multiplier, an extended Hamming (16,11) code with data in bits [10:0], check bits [15:11] and overall parity at bit 11. It accepts one codeword at a time over a valid/ready handshake and drives the external multiplier's operand. After a configurable latency it samples the 5-bit syndrome, classifies and corrects the error, and presents the decoded 11-bit data word. It also keeps saturating single-error and double-error statistics counters for the decoder top level.

Parameters:
MUL_LATENCY, 0, number of extra cycles after the operand is registered before mul_result is valid (0 = combinational multiplier)
CNT_W, 16, width of each error statistics counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  codeword_in is valid
in_ready  output  1  controller can accept a codeword
codeword_in  input  16  received codeword, possibly with errors
mul_operand  output  16  registered operand driven to the syndrome multiplier
mul_result  input  5  syndrome from the multiplier: [4:1] positional, [0] overall parity
out_valid  output  1  decoded result valid
out_ready  input  1  downstream accepts the result
data_out  output  11  corrected data bits [10:0]
err_single  output  1  single error detected and corrected
err_double  output  1  double error detected, uncorrectable
err_pos  output  4  corrected bit index (0-15); 0 when err_single=0
clr_counters  input  1  synchronous clear of both statistics counters
single_cnt  output  CNT_W  number of corrected single errors, saturating
double_cnt  output  CNT_W  number of detected double errors, saturating

Behaviour:
- Reset (asynchronous, active-high): state IDLE; mul_operand, data_out, err_*, err_pos, counters and internal registers all 0; out_valid=0; in_ready=1 once rst is released.
- FSM states: IDLE, WAIT, CORR, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register codeword_in into mul_operand and the internal codeword register, load the wait counter with MUL_LATENCY, and go to WAIT.
- WAIT:
  - If the wait counter is 0, register mul_result into the syndrome register and go to CORR.
  - Otherwise decrement the wait counter.
- CORR: classify the registered syndrome (s0 = bit 0, S = bits [4:1]):
  - s0=0, S=0: no error. data_out=cw[10:0].
  - s0=1, S=0: parity bit 11 in error. err_single=1, err_pos=11, data_out=cw[10:0].
  - s0=1, S!=0: single error. Flip the bit whose column matches S. Column map (S -> bit): 1111->0, 0111->1, 1011->2, 0011->3, 1101->4, 0101->5, 1001->6, 1110->7, 0110->8, 1010->9, 1100->10, 0001->12, 0010->13, 0100->14, 1000->15. Set err_single=1 and err_pos=bit.
  - S values with no column (0000 with s0=0 is the no-error case; all 16 values of S are mapped above or are 0000) never need a fallback.
  - s0=0, S!=0: double error. err_double=1, err_pos=0, data_out=cw[10:0] uncorrected.
  - All outputs are registered. The matching counter increments on the CORR->OUT edge. Go to OUT.
- OUT:
  - out_valid=1; data_out, err_* and err_pos are held stable.
  - On out_ready, drop out_valid and return to IDLE.
  - in_ready=0 in WAIT, CORR and OUT; there is no overlap between codewords.
- Latency: out_valid rises 3+MUL_LATENCY cycles after the accept cycle. Throughput is one codeword per 4+MUL_LATENCY cycles when out_ready=1.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_counters has priority over an increment in the same cycle, and the counter reads 0 afterwards.
  - clr_counters is honoured in any state.
- mul_operand holds its value after the handshake until the next accept.
- Reset asserted mid-operation returns the FSM to IDLE immediately. The in-flight codeword is dropped and the counters clear.

Test Plan:
- Clean word: codeword_in=16'h0000, MUL_LATENCY=0 -> out_valid 3 cycles after accept, data_out=11'h000, err_single=0, err_double=0, counters unchanged.
- Single error: 16'h0020 -> syndrome 5'b01011, data_out=11'h000, err_single=1, err_pos=5, single_cnt=1. Repeat with 16'h0800 -> err_pos=11, data_out=0.
- Double error: 16'h0021 -> syndrome 5'b10100, err_double=1, data_out=11'h021, double_cnt=1, err_pos=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid and data_out stable, in_ready=0, the second codeword is accepted only the cycle after out_ready=1. Repeat with MUL_LATENCY=2 -> latency 5.
- Counters: preload single_cnt to all-ones, inject a single error -> stays all-ones. Assert clr_counters in the CORR->OUT cycle -> single_cnt=0.
- Reset in WAIT: assert rst -> in_ready=1, out_valid=0, counters=0 after release; the next codeword decodes correctly.
